ext_mem_arbiter: RTL and testbench
==================================

// Module: ext_mem_arbiter
// PURPOSE
//  Shares the single external async SRAM port (CE/OE/WE, 16-bit addr/data) between the CPU
//  load/store path and the display glyph-fetch path. Grants one requester per transaction,
//  sequences the SRAM strobes with parameterised wait states and returns read data with a
//  one-cycle ack pulse. Sits between cpu/glyph logic and the chip pads.
// PARAMETERS
//  AW          16  address width
//  DW          16  data width
//  RD_WAIT     1   extra read wait cycles; RD state lasts RD_WAIT+1 cycles (>=0)
//  WR_PULSE    2   WE low duration in cycles (>=1)
//  MAX_STREAK  4   consecutive display grants allowed while CPU waits (>=1)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst          in   1   asynchronous, active-low reset
//  cpu_req      in   1   CPU request; held until cpu_ack
//  cpu_we       in   1   1=write, 0=read; stable while cpu_req
//  cpu_addr     in   AW  CPU address; stable while cpu_req
//  cpu_wdata    in   DW  CPU write data; stable while cpu_req
//  cpu_ack      out  1   one-cycle completion pulse
//  cpu_rdata    out  DW  read data; valid with cpu_ack, held until next CPU read ack
//  disp_req     in   1   display read request (read-only); held until disp_ack
//  disp_addr    in   AW  glyph address; stable while disp_req
//  disp_ack     out  1   one-cycle completion pulse
//  disp_rdata   out  DW  read data; valid with disp_ack, held until next display ack
//  mem_addr     out  AW  SRAM address (registered)
//  mem_dout     out  DW  SRAM write data (registered)
//  mem_dout_en  out  1   pad output enable for mem_dout
//  mem_din      in   DW  SRAM read data
//  CE           out  1   SRAM chip enable, active-low
//  OE           out  1   SRAM output enable, active-low
//  WE           out  1   SRAM write enable, active-low
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE; CE=OE=WE=1; mem_dout_en=0; mem_addr=mem_dout=0;
//    acks=0; cpu_rdata=disp_rdata=0; streak=0. Asserted mid-transaction: strobes release
//    immediately, no ack issued, requester must re-issue.
//  - FSM: IDLE -> RD -> DONE (read); IDLE -> WR_SU -> WR_P -> DONE (write); DONE -> IDLE.
//  - IDLE: all strobes high. Any req sampled -> pick grantee, register mem_addr (and
//    mem_dout for write) this edge.
//  - Arbitration when both req in IDLE: display wins unless streak==MAX_STREAK, then CPU wins.
//    streak: +1 per display grant made while cpu_req=1 (saturating); cleared on CPU grant or
//    on any display grant with cpu_req=0. Single requester always granted.
//  - RD: CE=0, OE=0 for RD_WAIT+1 cycles; mem_din captured into grantee rdata on last RD edge.
//  - WR_SU: 1 cycle, CE=0, WE=1, mem_dout_en=1. WR_P: WR_PULSE cycles, CE=0, WE=0.
//  - DONE: CE=OE=WE=1 (turnaround); grantee ack=1 this cycle only; mem_dout_en stays 1 in
//    DONE after a write (data hold), 0 otherwise.
//  - Latency, counting IDLE-sample cycle as 1: read ack in cycle RD_WAIT+3 (default 4);
//    write ack in cycle WR_PULSE+3 (default 5). Min 1 IDLE cycle between transactions.
//  - req dropped mid-transaction: ignored, transaction completes, ack still pulses.
//  - req/addr sampled only in IDLE; changes during a transaction have no effect.
//  - OE and WE never low simultaneously; mem_dout_en never 1 while OE=0.
//  - Wait counter width: clog2(max(RD_WAIT,WR_PULSE)+1); reloaded on every state entry.
// STRUCTURE
//  - Shared package: state encodings (IDLE, RD, WR_SU, WR_P, DONE), grantee IDs
//    (GNT_CPU, GNT_DISP), strobe polarity constants.
//  - One sub-module: mem_wait_counter (load/decrement/zero flag) used by RD and WR_P.
// TESTING
//  1 CPU read 0x0040, SRAM model returns 0xBEEF -> OE low 2 cycles, cpu_ack cycle 4,
//    cpu_rdata=0xBEEF.
//  2 CPU write 0x0041<-0x0005 -> WE low exactly 2 cycles, mem_dout_en 1 across WR_SU..DONE,
//    SRAM[0x0041]=0x0005, cpu_ack cycle 5.
//  3 cpu_req and disp_req held continuously -> grant order D,D,D,D,C,D,D,D,D,C...
//    (MAX_STREAK=4); no overlapping strobes.
//  4 disp_req only, 8 back-to-back reads 0x1000..0x1007 -> 8 disp_acks, data correct,
//    one idle cycle between transactions, streak stays 0.
//  5 rst=0 asserted during WR_P -> CE/WE high same cycle, no cpu_ack; after release
//    re-issued write completes normally.
//  6 cpu_req dropped in RD cycle 1 -> ack still pulses at cycle 4; next IDLE sees no request.

Source files
------------

// File: rtl/ext_mem_arbiter_pkg.sv
// Shared definitions for the external SRAM arbiter: FSM states, grantee IDs,
// strobe polarity and a small sizing helper.
package ext_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR_SU = 3'd2,
    WR_P  = 3'd3,
    DONE  = 3'd4
  } arb_state_e;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_DISP = 1'b1
  } gnt_e;

  // SRAM strobes (CE/OE/WE) are active-low.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ext_mem_arbiter_wait_counter.sv
// Down-counter sequencing SRAM wait states: load on state entry, decrement
// while enabled, zero flag marks the last cycle of the timed state.
module mem_wait_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ext_mem_arbiter.sv
// Arbitrates the single async SRAM port between CPU load/store and display
// glyph fetch, sequencing CE/OE/WE with parameterised wait states.
module ext_mem_arbiter
  import ext_mem_arbiter_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int RD_WAIT    = 1,
  parameter int WR_PULSE   = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  // Handshake: a requester raises req with stable we/addr/wdata and keeps it
  // up until its one-cycle ack; req is only sampled in IDLE, so dropping it
  // mid-transaction does not cancel the access and the ack still pulses.
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_ack,
  output logic [DW-1:0] disp_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dout,
  output logic          mem_dout_en,
  input  logic [DW-1:0] mem_din,
  output logic          CE,
  output logic          OE,
  output logic          WE,
  output arb_state_e    dbg_state
);

  localparam int CW = $clog2(max_int(RD_WAIT, WR_PULSE) + 1);
  localparam int SW = $clog2(MAX_STREAK + 1);

  arb_state_e    state, state_d;
  gnt_e          gnt;
  logic          gnt_we;
  logic [SW-1:0] streak;
  logic          take, pick_disp;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_val;

  mem_wait_counter #(.CW(CW)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state;
    take      = 1'b0;
    pick_disp = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || disp_req) begin
          take      = 1'b1;
          // Display has priority until it has starved the CPU MAX_STREAK times.
          pick_disp = disp_req && !(cpu_req && (streak == SW'(MAX_STREAK)));
          if (!pick_disp && cpu_we) begin
            state_d = WR_SU;
          end else begin
            state_d  = RD;
            cnt_load = 1'b1;
            cnt_val  = CW'(RD_WAIT);
          end
        end
      end
      RD: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = DONE;
      end
      WR_SU: begin
        state_d  = WR_P;
        cnt_load = 1'b1;
        cnt_val  = CW'(WR_PULSE - 1);
      end
      WR_P: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= GNT_CPU;
      gnt_we     <= 1'b0;
      streak     <= '0;
      mem_addr   <= '0;
      mem_dout   <= '0;
      cpu_rdata  <= '0;
      disp_rdata <= '0;
    end else begin
      state <= state_d;
      if (take) begin
        gnt      <= pick_disp ? GNT_DISP : GNT_CPU;
        gnt_we   <= !pick_disp && cpu_we;
        mem_addr <= pick_disp ? disp_addr : cpu_addr;
        if (!pick_disp && cpu_we) mem_dout <= cpu_wdata;
        if (pick_disp && cpu_req) begin
          if (streak != SW'(MAX_STREAK)) streak <= streak + SW'(1);
        end else begin
          streak <= '0;
        end
      end
      if ((state == RD) && cnt_zero) begin
        if (gnt == GNT_CPU) cpu_rdata  <= mem_din;
        else                disp_rdata <= mem_din;
      end
    end
  end

  // Strobes decode straight from the state register so reset releases them at once.
  assign CE          = (state == RD || state == WR_SU || state == WR_P) ? STROBE_ON : STROBE_OFF;
  assign OE          = (state == RD)   ? STROBE_ON : STROBE_OFF;
  assign WE          = (state == WR_P) ? STROBE_ON : STROBE_OFF;
  assign mem_dout_en = gnt_we && (state == WR_SU || state == WR_P || state == DONE);
  assign cpu_ack     = (state == DONE) && (gnt == GNT_CPU);
  assign disp_ack    = (state == DONE) && (gnt == GNT_DISP);
  assign dbg_state   = state;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Self-checking bench for ext_mem_arbiter: async SRAM model, directed vector
// table, multi-cycle corner sequences and randomized traffic against a model.
module tb_ext_mem_arbiter;
  import ext_mem_arbiter_pkg::*;

  localparam int AW = 16, DW = 16, RD_WAIT = 1, WR_PULSE = 2, MAX_STREAK = 4;
  localparam int RD_LAT = RD_WAIT + 3;
  localparam int WR_LAT = WR_PULSE + 3;
  localparam int TXN_BUDGET = 40;

  logic clk = 1'b0, rst = 1'b0;
  logic cpu_req = 0, cpu_we = 0, disp_req = 0;
  logic [AW-1:0] cpu_addr = '0, disp_addr = '0, mem_addr;
  logic [DW-1:0] cpu_wdata = '0, cpu_rdata, disp_rdata, mem_dout, mem_din;
  logic cpu_ack, disp_ack, mem_dout_en, CE, OE, WE;
  arb_state_e dbg_state;

  logic [DW-1:0] sram [0:65535];
  logic [DW-1:0] mdl  [0:65535];
  logic [DW-1:0] exp_q [$];

  int vectors = 0, miscompares = 0, viol = 0;

  ext_mem_arbiter #(.AW(AW), .DW(DW), .RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE),
                    .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_rdata(disp_rdata),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_dout_en(mem_dout_en), .mem_din(mem_din),
    .CE(CE), .OE(OE), .WE(WE), .dbg_state(dbg_state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- async SRAM model ----
  assign mem_din = (!CE && !OE) ? sram[mem_addr] : '0;
  always @(posedge clk) begin
    if (rst && !CE && !WE && mem_dout_en) sram[mem_addr] = mem_dout;
  end

  // ---- bus protocol monitor ----
  always @(negedge clk) begin
    if (rst) begin
      if (!OE && !WE) viol++;
      if (mem_dout_en && !OE) viol++;
      if (cpu_ack && disp_ack) viol++;
    end
  end

  function automatic logic [DW-1:0] init_pat(input int a);
    logic [DW-1:0] v;
    v = DW'(a);
    return (v * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---- driver: one single-requester transaction, called #1 after an edge in IDLE ----
  task automatic do_txn(input bit is_cpu, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output int lat, output int oe_lo,
                        output int we_lo, output int en_hi, output logic [DW-1:0] rd);
    int n;
    lat = -1; oe_lo = 0; we_lo = 0; en_hi = 0; rd = '0; n = 0;
    if (is_cpu) begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      disp_req = 1; disp_addr = addr;
    end
    while (lat < 0 && n < TXN_BUDGET) begin
      @(posedge clk); #1; n++;
      if (!OE) oe_lo++;
      if (!WE) we_lo++;
      if (mem_dout_en) en_hi++;
      if (is_cpu ? cpu_ack : disp_ack) begin
        lat = n + 1;
        rd  = is_cpu ? cpu_rdata : disp_rdata;
      end
    end
    cpu_req = 0; disp_req = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_data;
    int            exp_lat;
    int            exp_oe;
    int            exp_we;
    int            exp_en;
  } vec_t;

  vec_t vt [6];

  initial begin
    int lat, oe_lo, we_lo, en_hi, n, streak, ce_lo, acks;
    logic [DW-1:0] rd;
    logic [DW-1:0] got [$];

    for (int a = 0; a < 65536; a++) begin
      sram[a] = init_pat(a);
      mdl[a]  = init_pat(a);
    end
    sram[16'h0040] = 16'hBEEF; mdl[16'h0040] = 16'hBEEF;
    sram[16'h0041] = 16'h0000; mdl[16'h0041] = 16'h0000;
    sram[16'h0042] = 16'h1357; mdl[16'h0042] = 16'h1357;

    vt[0] = '{0, 16'h0040, 16'h0000, 16'hBEEF, RD_LAT, RD_WAIT + 1, 0, 0};
    vt[1] = '{1, 16'h0041, 16'h0005, 16'h0005, WR_LAT, 0, WR_PULSE, WR_PULSE + 2};
    vt[2] = '{0, 16'h0041, 16'h0000, 16'h0005, RD_LAT, RD_WAIT + 1, 0, 0};
    vt[3] = '{0, 16'h0042, 16'h0000, 16'h1357, RD_LAT, RD_WAIT + 1, 0, 0};
    vt[4] = '{1, 16'hFFFF, 16'hA5A5, 16'hA5A5, WR_LAT, 0, WR_PULSE, WR_PULSE + 2};
    vt[5] = '{0, 16'hFFFF, 16'h0000, 16'hA5A5, RD_LAT, RD_WAIT + 1, 0, 0};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {29'd0, CE, OE, WE}, 32'h7);
    check("rst_dout_en", mem_dout_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_dout", mem_dout, 0);
    check("rst_acks", {cpu_ack, disp_ack}, 0);
    check("rst_rdata", {cpu_rdata, disp_rdata}, 0);
    rst = 1;
    @(posedge clk); #1;

    // ---- directed CPU vector table ----
    foreach (vt[i]) begin
      do_txn(1, vt[i].we, vt[i].addr, vt[i].wdata, lat, oe_lo, we_lo, en_hi, rd);
      check($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
      check($sformatf("vec%0d_oe_cycles", i), oe_lo, vt[i].exp_oe);
      check($sformatf("vec%0d_we_cycles", i), we_lo, vt[i].exp_we);
      check($sformatf("vec%0d_dout_en_cycles", i), en_hi, vt[i].exp_en);
      if (vt[i].we) check($sformatf("vec%0d_sram", i), sram[vt[i].addr], vt[i].exp_data);
      else          check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_data);
    end
    mdl[16'h0041] = 16'h0005;
    mdl[16'hFFFF] = 16'hA5A5;

    // ---- display-only back-to-back burst ----
    for (int i = 0; i < 8; i++) exp_q.push_back(mdl[16'h1000 + i]);
    disp_req = 1; disp_addr = 16'h1000; n = 0; lat = 0; acks = 0;
    while (acks < 8 && n < 200) begin
      @(posedge clk); #1; n++; lat++;
      if (disp_ack) begin
        check($sformatf("burst%0d_data", acks), disp_rdata, exp_q.pop_front());
        if (acks > 0) check($sformatf("burst%0d_spacing", acks), lat, RD_LAT);
        lat = 0; acks++;
        disp_addr = 16'h1000 + AW'(acks);
      end
    end
    check("burst_ack_count", acks, 8);
    disp_req = 0;
    @(posedge clk); #1;

    // ---- both requesters held: expected grant order from the streak rule ----
    streak = 0;
    for (int g = 0; g < 15; g++) begin
      if (streak == MAX_STREAK) begin exp_q.push_back(DW'(GNT_CPU));  streak = 0; end
      else                      begin exp_q.push_back(DW'(GNT_DISP)); streak++;   end
    end
    cpu_we = 0; cpu_addr = 16'h2000; disp_addr = 16'h3000;
    cpu_req = 1; disp_req = 1; n = 0;
    while (got.size() < 15 && n < 400) begin
      @(posedge clk); #1; n++;
      if (cpu_ack)  begin got.push_back(DW'(GNT_CPU));  check("contend_cpu_data", cpu_rdata, mdl[16'h2000]); end
      if (disp_ack) begin got.push_back(DW'(GNT_DISP)); check("contend_disp_data", disp_rdata, mdl[16'h3000]); end
    end
    cpu_req = 0; disp_req = 0;
    @(posedge clk); #1;
    check("contend_grant_count", got.size(), 15);
    foreach (got[i]) check($sformatf("contend_grant%0d", i), got[i], exp_q[i]);
    exp_q.delete();

    // ---- reset during the write pulse ----
    sram[16'h0050] = 16'h0000;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0050; cpu_wdata = 16'h1234;
    repeat (2) begin @(posedge clk); #1; end
    check("wrp_we_low", WE, 0);
    rst = 0; #1;
    check("rstmid_strobes", {29'd0, CE, OE, WE}, 32'h7);
    check("rstmid_ack", cpu_ack, 0);
    check("rstmid_dout_en", mem_dout_en, 0);
    cpu_req = 0;
    repeat (2) @(posedge clk);
    #1; check("rstmid_ack_held", cpu_ack, 0);
    rst = 1;
    @(posedge clk); #1;
    check("rstmid_no_write", sram[16'h0050], 16'h0000);
    do_txn(1, 1, 16'h0050, 16'h1234, lat, oe_lo, we_lo, en_hi, rd);
    check("reissue_lat", lat, WR_LAT);
    check("reissue_sram", sram[16'h0050], 16'h1234);
    mdl[16'h0050] = 16'h1234;

    // ---- request dropped in the first read cycle ----
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040; lat = -1;
    @(posedge clk); #1; n = 1;
    cpu_req = 0;
    while (lat < 0 && n < TXN_BUDGET) begin
      @(posedge clk); #1; n++;
      if (cpu_ack) lat = n + 1;
    end
    check("drop_lat", lat, RD_LAT);
    check("drop_rdata", cpu_rdata, 16'hBEEF);
    ce_lo = 0; acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (!CE) ce_lo++;
      if (cpu_ack || disp_ack) acks++;
    end
    check("drop_no_new_txn", ce_lo, 0);
    check("drop_no_new_ack", acks, 0);
    check("cpu_rdata_held", cpu_rdata, 16'hBEEF);

    // ---- randomized single-requester traffic vs. model memory ----
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      kind = $urandom_range(0, 2);
      a    = 16'h0100 + AW'($urandom_range(0, 15));
      d    = DW'($urandom);
      if (kind == 1) begin
        do_txn(1, 1, a, d, lat, oe_lo, we_lo, en_hi, rd);
        mdl[a] = d;
        check($sformatf("rnd%0d_wr_lat", i), lat, WR_LAT);
        check($sformatf("rnd%0d_wr_sram", i), sram[a], mdl[a]);
      end else begin
        do_txn(kind == 0, 0, a, '0, lat, oe_lo, we_lo, en_hi, rd);
        check($sformatf("rnd%0d_rd_lat", i), lat, RD_LAT);
        check($sformatf("rnd%0d_rd_data", i), rd, mdl[a]);
      end
    end

    check("protocol_violations", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
